// File: rtl/cla_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cla_pipe : skewed pipelined carry-lookahead adder/subtractor with flags
// Rev 1.0
// ---------------------------------------------------------------------------
module cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;
  localparam int LV = $clog2(NG + 1);

  // Group carries come from a parallel-prefix tree over (G,P) pairs with the
  // slice carry-in as element 0, so no carry ripples from group to group.
  function automatic logic [SW:0] cla_add(input logic [SW-1:0] x,
                                          input logic [SW-1:0] y,
                                          input logic          ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] c;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   gt [0:LV];
    logic [NG:0]   pt [0:LV];
    logic          c0;
    int            d;
    int            base;
    g = x & y;
    p = x ^ y;
    c = '0;
    for (int j = 0; j < NG; j++) begin
      base     = 4 * j;
      grp_g[j] = g[base+3] | (p[base+3] & g[base+2]) |
                 (p[base+3] & p[base+2] & g[base+1]) |
                 (p[base+3] & p[base+2] & p[base+1] & g[base]);
      grp_p[j] = &p[base +: 4];
    end
    gt[0] = {grp_g, ci};
    pt[0] = {grp_p, 1'b0};
    for (int l = 1; l <= LV; l++) begin
      d = 1 << (l - 1);
      for (int i = 0; i <= NG; i++) begin
        if (i >= d) begin
          gt[l][i] = gt[l-1][i] | (pt[l-1][i] & gt[l-1][i-d]);
          pt[l][i] = pt[l-1][i] & pt[l-1][i-d];
        end else begin
          gt[l][i] = gt[l-1][i];
          pt[l][i] = pt[l-1][i];
        end
      end
    end
    for (int j = 0; j < NG; j++) begin
      base      = 4 * j;
      c0        = gt[LV][j];
      c[base]   = c0;
      c[base+1] = g[base] | (p[base] & c0);
      c[base+2] = g[base+1] | (p[base+1] & g[base]) | (&p[base +: 2] & c0);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1]) |
                  (p[base+2] & p[base+1] & g[base]) | (&p[base +: 3] & c0);
    end
    return {gt[LV][NG], p ^ c};
  endfunction

  logic [WIDTH-1:0]  bb;
  logic              cin0;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic              adv_t;

  assign bb       = sub ? ~b : b;
  assign cin0     = sub | c_in;
  assign in_ready = adv[0];

  always_comb begin
    adv   = '0;
    adv_t = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_t  = ~v[k] | adv_t;
      adv[k] = adv_t;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BASE = k * SW;
    localparam int LO   = BASE + SW;
    localparam int REM  = WIDTH - BASE;

    logic [REM-1:0] opa;
    logic [REM-1:0] opb;
    logic           ci;
    logic           vi;
    logic [SW:0]    res;
    logic [LO-1:0]  sum_d;
    logic [LO-1:0]  sum_q;
    logic           v_q;

    if (k == 0) begin : g_head
      assign opa   = a;
      assign opb   = bb;
      assign ci    = cin0;
      assign vi    = in_valid & adv[0];
      assign sum_d = res[SW-1:0];
    end else begin : g_body
      assign opa   = g_stage[k-1].g_fwd.a_q;
      assign opb   = g_stage[k-1].g_fwd.b_q;
      assign ci    = g_stage[k-1].g_fwd.cy_q;
      assign vi    = v[k-1];
      assign sum_d = {res[SW-1:0], g_stage[k-1].sum_q};
    end

    assign res  = cla_add(opa[SW-1:0], opb[SW-1:0], ci);
    assign v[k] = v_q;

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        v_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv[k]) begin
        v_q   <= vi;
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      logic              cy_q;

      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          a_q  <= '0;
          b_q  <= '0;
          cy_q <= 1'b0;
        end else if (adv[k]) begin
          a_q  <= opa[REM-1:SW];
          b_q  <= opb[REM-1:SW];
          cy_q <= res[SW];
        end
      end
    end else begin : g_tail
      logic c_q;
      logic ovf_q;
      logic zero_q;

      // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv[k]) begin
          c_q    <= res[SW];
          ovf_q  <= res[SW] ^ res[SW-1] ^ opa[SW-1] ^ opb[SW-1];
          zero_q <= ~|sum_d;
        end
      end

      assign s         = sum_q;
      assign c_out     = c_q;
      assign ovf       = ovf_q;
      assign zero      = zero_q;
      assign out_valid = v_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cla_pipe : self-checking bench for cla_pipe at STAGES = 2, 1 and 8
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cla_pipe;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
    int          t;
  } item_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid_x  [3];
  logic        in_ready_x  [3];
  logic        sub_x       [3];
  logic        cin_x       [3];
  logic        out_valid_x [3];
  logic        out_ready_x [3];
  logic        cout_x      [3];
  logic        ovf_x       [3];
  logic        zero_x      [3];
  logic [31:0] a_x         [3];
  logic [31:0] b_x         [3];
  logic [31:0] s_x         [3];

  item_t q[$];
  int    cur;
  int    edge_n;
  int    last_ret;
  int    passes;
  int    total;
  int    accepted;
  logic  acc;

  logic [31:0] da   [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003, 32'h0000_FFFF, 32'h7FFF_FFFF};
  logic [31:0] db   [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
  logic        dsub [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        dcin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] es   [5] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0001_0000, 32'h8000_0000};
  logic        ec   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        eo   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    cla_pipe #(
      .WIDTH (32),
      .STAGES((i == 0) ? 2 : ((i == 1) ? 1 : 8))
    ) u_dut (
      .clk      (clk),
      .clrn     (clrn),
      .in_valid (in_valid_x[i]),
      .in_ready (in_ready_x[i]),
      .a        (a_x[i]),
      .b        (b_x[i]),
      .sub      (sub_x[i]),
      .c_in     (cin_x[i]),
      .out_valid(out_valid_x[i]),
      .out_ready(out_ready_x[i]),
      .s        (s_x[i]),
      .c_out    (cout_x[i]),
      .ovf      (ovf_x[i]),
      .zero     (zero_x[i])
    );
  end

  function automatic int stg(input int d);
    if (d == 0) return 2;
    if (d == 1) return 1;
    return 8;
  endfunction

  // Reference: plain 33-bit arithmetic, signed overflow from operand/result signs.
  function automatic item_t model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic isub, input logic icin);
    item_t       r;
    logic [31:0] bx;
    logic [32:0] tot;
    bx    = isub ? ~ib : ib;
    tot   = {1'b0, ia} + {1'b0, bx} + {32'd0, (isub ? 1'b1 : icin)};
    r.s   = tot[31:0];
    r.c   = tot[32];
    r.v   = (ia[31] == bx[31]) && (r.s[31] != ia[31]);
    r.z   = (r.s == 32'd0);
    r.t   = 0;
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // An op accepted at edge t is visible from edge t+S-1, but never before
  // the edge at which its predecessor retired.
  task automatic check_state(output logic ev, output logic er);
    int n_st;
    int ready_at;
    n_st = stg(cur);
    ev   = 1'b0;
    if (q.size() > 0) begin
      ready_at = q[0].t + n_st - 1;
      if (last_ret > ready_at) ready_at = last_ret;
      ev = (edge_n >= ready_at);
    end
    er = (q.size() < n_st) || out_ready_x[cur];
    chk1("out_valid", out_valid_x[cur], ev);
    chk1("in_ready", in_ready_x[cur], er);
    if (ev) begin
      chk32("s", s_x[cur], q[0].s);
      chk1("c_out", cout_x[cur], q[0].c);
      chk1("ovf", ovf_x[cur], q[0].v);
      chk1("zero", zero_x[cur], q[0].z);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic isub, input logic icin, input logic ordy,
                      output logic took);
    item_t it;
    logic  ev;
    logic  er;
    in_valid_x[cur]  = iv;
    a_x[cur]         = ia;
    b_x[cur]         = ib;
    sub_x[cur]       = isub;
    cin_x[cur]       = icin;
    out_ready_x[cur] = ordy;
    #1;
    check_state(ev, er);
    took = iv & er;
    if (ev && ordy) begin
      void'(q.pop_front());
      last_ret = edge_n + 1;
    end
    if (took) begin
      it   = model(ia, ib, isub, icin);
      it.t = edge_n + 1;
      q.push_back(it);
    end
    @(posedge clk);
    edge_n = edge_n + 1;
    @(negedge clk);
  endtask

  task automatic rand_step(input logic iv, input logic ordy, output logic took);
    step(iv, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ordy, took);
  endtask

  task automatic drain();
    logic took;
    for (int n = 0; n < 64 && q.size() > 0; n++) rand_step(1'b0, 1'b1, took);
    chk32("drain_timeout", 32'(q.size()), 32'd0);
    rand_step(1'b0, 1'b1, took);
  endtask

  task automatic reset_mid();
    #2;
    clrn = 1'b0;
    #1;
    chk1("rst_out_valid", out_valid_x[cur], 1'b0);
    chk32("rst_s", s_x[cur], 32'd0);
    chk1("rst_c_out", cout_x[cur], 1'b0);
    chk1("rst_ovf", ovf_x[cur], 1'b0);
    chk1("rst_zero", zero_x[cur], 1'b0);
    chk1("rst_in_ready", in_ready_x[cur], 1'b1);
    q.delete();
    in_valid_x[cur] = 1'b1;
    a_x[cur]        = $urandom;
    @(posedge clk);
    edge_n = edge_n + 1;
    #1;
    chk1("rst_hold_valid", out_valid_x[cur], 1'b0);
    chk1("rst_hold_ready", in_ready_x[cur], 1'b1);
    @(negedge clk);
    clrn            = 1'b1;
    in_valid_x[cur] = 1'b0;
    last_ret        = edge_n;
  endtask

  initial begin
    clrn     = 1'b0;
    cur      = 0;
    edge_n   = 0;
    last_ret = 0;
    passes   = 0;
    total    = 0;
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid_x[i]  = 1'b0;
      out_ready_x[i] = 1'b1;
      a_x[i]         = 32'd0;
      b_x[i]         = 32'd0;
      sub_x[i]       = 1'b0;
      cin_x[i]       = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("init_out_valid", out_valid_x[i], 1'b0);
      chk1("init_in_ready", in_ready_x[i], 1'b1);
      chk32("init_s", s_x[i], 32'd0);
      chk1("init_zero", zero_x[i], 1'b0);
    end
    @(negedge clk);
    clrn = 1'b1;

    // Directed corner cases, each held at the output for a fixed-value check.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, da[i], db[i], dsub[i], dcin[i], 1'b0, acc);
      for (int j = 0; j < stg(cur) - 1; j++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
      #1;
      chk32("dir_s", s_x[cur], es[i]);
      chk1("dir_c_out", cout_x[cur], ec[i]);
      chk1("dir_ovf", ovf_x[cur], eo[i]);
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    end

    for (int i = 0; i < 16; i++) rand_step(1'b1, 1'b1, acc);
    drain();

    for (int i = 0; i < 5; i++) rand_step(1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) rand_step(1'b1, 1'b1, acc);
    drain();

    for (int n = 0; n < 20000 && accepted < 1000; n++) begin
      rand_step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), acc);
      if (acc) accepted = accepted + 1;
    end
    chk32("rand_accepted", 32'(accepted), 32'd1000);
    drain();

    for (int d = 0; d < 3; d++) begin
      cur = d;
      rand_step(1'b1, 1'b0, acc);
      rand_step(1'b1, 1'b0, acc);
      reset_mid();
      for (int i = 0; i < 3; i++) rand_step(1'b0, 1'b1, acc);
      step(1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, acc);
      for (int j = 0; j < stg(cur) - 1; j++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
      #1;
      chk1("post_rst_valid", out_valid_x[cur], 1'b1);
      chk32("post_rst_s", s_x[cur], 32'd3);
      drain();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the integer and FPU mantissa datapaths. It splits a WIDTH-bit add into STAGES equal slices built from 4-bit lookahead groups and registers the slice carry between stages. A valid/ready handshake on both sides gives one result per cycle at a fixed STAGES-cycle latency. Each result carries flags (carry, signed overflow, zero) for the execute stage and the FPU normaliser.

## Interface
Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 4 and at least 4.
- STAGES, 2, number of pipeline stages. Must be at least 1, and WIDTH/4 must be divisible by STAGES. Slice width is SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  an operand set is presented.
- in_ready  out  1  the pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 computes a+b+c_in; 1 computes a+~b+1 (c_in ignored).
- c_in  in  1  carry-in for add mode.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- s  out  WIDTH  sum/difference, modulo 2^WIDTH.
- c_out  out  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  s == 0.

## Operation
- Operand preparation at input, combinational: bb = sub ? ~b : b; cin0 = sub ? 1 : c_in.
- Stage k (0..STAGES-1):
  - Adds slice k of a and bb, bits [k*SW +: SW], using the carry registered by stage k-1 (cin0 for stage 0).
  - Each slice is a carry-lookahead tree of 4-bit groups with group generate/propagate. There is no ripple between groups inside a slice.
- Skewed pipeline:
  - Each stage register holds the sum bits already computed, the not-yet-added upper operand bits, the slice carry-out, and a valid bit v[k].
  - Unused upper operand bits are not held in the last stage.
- Flags are computed in the last stage, from the final slice:
  - c_out = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = ~|s.
- Outputs s, c_out, ovf, zero and out_valid come directly from the last stage register.
- Handshake, per stage:
  - adv[STAGES-1] = ~v[STAGES-1] | out_ready.
  - adv[k] = ~v[k] | adv[k+1].
  - in_ready = adv[0]. This is combinational from out_ready and the valid bits.
- On each clock edge, for every stage with adv[k]=1:
  - the stage loads from its upstream stage (the input for k=0);
  - v[k] takes the upstream valid bit (in_valid & in_ready for k=0).
- A stage with adv[k]=0 holds its contents.
- Bubbles collapse: an empty stage always accepts, so throughput is 1 op/cycle while out_ready=1.
- A transfer occurs on valid & ready at either port. An unaccepted input may change freely; the block samples it only when in_valid & in_ready.
- Results leave strictly in input order. No result is dropped or duplicated.

## Timing
- Reset (clrn=0, asynchronous, takes effect immediately):
  - all v[k]=0, so out_valid=0;
  - s=0, c_out=0, ovf=0, zero=0 (data registers cleared);
  - in_ready=1 for the whole reset period.
- Reset mid-operation: every in-flight op is discarded. No output appears for them after clrn rises.
- First accept is possible on the first rising edge with clrn=1.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1. With STAGES=1 the result is visible the cycle after acceptance.
- While out_valid=1 and out_ready=0, s, c_out, ovf and zero hold stable.
- Pipeline full with out_ready=0: in_ready=0 in the same cycle. Capacity is exactly STAGES ops.
- Simultaneous events:
  - out_ready=1 and in_valid=1 while full: one result retires and one input is accepted on the same edge (in_ready=1).
- Critical path per stage: one SW-bit lookahead tree plus operand-inversion muxing (stage 0 only).

## Test plan
- WIDTH=32, STAGES=2, add: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> s=0x00000000, c_out=1, ovf=0, zero=1. out_valid rises 2 edges after acceptance.
- Sub, signed overflow: a=0x80000000, b=0x00000001, sub=1 -> s=0x7FFFFFFF, c_out=1, ovf=1, zero=0. Also a=0x00000003, b=0x00000005, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0.
- Carry across a stage boundary and c_in: a=0x0000FFFF, b=0, c_in=1 -> s=0x00010000, c_out=0. Also a=0x7FFFFFFF, b=0, c_in=1 -> s=0x80000000, ovf=1.
- Streaming: 16 random ops back-to-back with out_ready=1 -> 16 results on consecutive cycles, in order, each matching a reference model. in_ready stays 1 throughout.
- Backpressure: continuous in_valid, out_ready=0 for 5 cycles then 1 -> in_ready falls once 2 ops are held, and outputs stay stable while stalled. On release, results resume in order with no loss or duplicates. Randomised out_ready for 1000 ops checks the same property.
- Reset mid-stream: assert clrn=0 with 2 ops in flight -> out_valid=0 and s=0 immediately, without waiting for a clock edge, and in_ready=1. After release, no stale result appears, and a new op a=1, b=2 returns s=3 after 2 edges. Repeat with STAGES=1 and with STAGES=8 (WIDTH=32).
